regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port controller for the 32×32 register file (`regFile`, ports `WE3`/`WA3`/`WD3`). After reset it zeroes x1–x31 in an init sweep. It then shares the single write port between two requesters:
- the single-cycle core writeback (priority, no handshake);
- an auxiliary multi-cycle unit (divider/CSR/debug) using a valid/ready handshake.

A starvation counter stalls the core so the auxiliary requester is served within a bounded time.

## Interface
Parameters:
- `XLEN`, 32, data width of the write port
- `AW`, 5, register address width
- `MAX_WAIT`, 4, maximum consecutive cycles a valid aux request may go unserved before the core is stalled (range 1–15)

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `core_we`  in  1  core writeback request
- `core_wa`  in  AW  core destination register
- `core_wd`  in  XLEN  core writeback data
- `core_stall`  out  1  core must hold its PC and write inputs this cycle
- `aux_valid`  in  1  aux write request valid
- `aux_wa`  in  AW  aux destination register
- `aux_wd`  in  XLEN  aux write data
- `aux_ready`  out  1  aux request accepted at this edge when `aux_valid` is also high
- `init_busy`  out  1  init sweep in progress
- `WE3`  out  1  to `regFile.WE3`
- `WA3`  out  AW  to `regFile.WA3`
- `WD3`  out  XLEN  to `regFile.WD3`

## Operation
- **States:** `INIT` and `RUN`.
- **Reset:** synchronous reset moves to `INIT`, sets `init_cnt`=1 and sets `wait_cnt`=0.
- **`INIT` state:**
  - Outputs: `WE3`=1, `WA3`=`init_cnt`, `WD3`=0, `init_busy`=1, `core_stall`=1, `aux_ready`=0.
  - `init_cnt` increments each cycle.
  - When `init_cnt`==31, the next state is `RUN`. The sweep lasts 31 cycles.
- **Effective requests in `RUN`:** `core_eff` = `core_we` & (`core_wa`≠0).
- **Starvation threshold:** `starve` = `aux_valid` & (`wait_cnt`==`MAX_WAIT`).
- **Grant rules in `RUN`:**
  - If `starve`: `core_stall`=1, `aux_ready`=1, and the port carries the aux write. The core's write is dropped this cycle; the core re-presents it next cycle because it held.
  - Else if `core_eff`: `core_stall`=0, `aux_ready`=0, and the port carries the core write.
  - Else: `core_stall`=0 and `aux_ready`=`aux_valid`. The port carries the aux write if granted; otherwise `WE3`=0.
- **x0 writes:** an aux write to x0 is accepted (handshake completes) but drives `WE3`=0. A core write to x0 never drives `WE3`.
- **`wait_cnt` update (RUN only):**
  - Cleared on an aux handshake or when `aux_valid`=0.
  - Incremented when `aux_valid` & ~`aux_ready`.
  - Saturates at `MAX_WAIT`.
- **Aux request stability:** aux inputs must stay stable while `aux_valid` & ~`aux_ready`. `aux_valid` may only drop after a handshake.
- **Idle port:** when `WE3`=0, `WA3`=0 and `WD3`=0 so the port is free of X.
- **Reset asserted:** outputs are forced combinationally to `WE3`=0, `aux_ready`=0, `core_stall`=1, `init_busy`=1. Reset mid-sweep or mid-`RUN` restarts the sweep at x1.

## Timing
- Outputs are combinational from state and inputs; the selected write lands in `regFile` at the same rising edge (zero added latency, matching single-cycle writeback).
- Sweep: the first write (x1) occurs on the first edge after reset deasserts, and the last (x31) 30 edges later. `init_busy` falls the cycle after the x31 write.
- Worst-case aux latency from `aux_valid` rising to handshake: `MAX_WAIT`+1 edges under continuous core writes; 1 edge if the core is idle.
- Core stall costs exactly one cycle per forced aux grant.
- No path from `aux_ready` to `aux_valid` is allowed inside this block (no combinational loop with the requester).

## Structure
- Shared package `regfile_pkg`:
  - `XLEN`, `AW`, `NREGS`=32;
  - `typedef enum logic {INIT, RUN} wb_state_t`;
  - `typedef struct {we, wa, wd} rf_wr_t` used for the port mux.
- One flop block for state, `init_cnt` and `wait_cnt`, plus one combinational grant/mux block.
- No sub-module needed; `regFile` is instantiated by the parent, not here.

## Test plan
- **Init sweep:** reset for 2 cycles, then release → `WE3`=1 with `WA3` going 1..31 and `WD3`=0 on 31 consecutive edges. `init_busy`=1 throughout, then 0; afterwards `regFile` reads of x1–x31 return 0.
- **Core only:** `core_we`=1, `core_wa`=1, `core_wd`=12345678 in `RUN` → same-edge write; `RD1` at RA1=1 reads 12345678. `core_wa`=0 → `WE3`=0.
- **Aux on idle core:** `aux_valid`=1, `aux_wa`=2, `aux_wd`=0xDEADBEEF, `core_we`=0 → `aux_ready`=1 in the same cycle; x2 = 0xDEADBEEF; `core_stall` stays 0.
- **Starvation:** `core_we`=1 every cycle, `aux_valid` held with `MAX_WAIT`=4 → 4 cycles of core writes, then one cycle with `core_stall`=1, `aux_ready`=1 and the aux write on the port. The following cycle the core write resumes and `wait_cnt`=0.
- **Aux to x0:** `aux_valid`=1, `aux_wa`=0 → handshake completes, `WE3`=0, and x0 still reads 0.
- **Reset mid-operation:** assert `reset` at sweep index 10 and again during a pending aux wait → outputs go to their reset values at once. The sweep restarts at x1, and the pending aux request is not acknowledged until `RUN`.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file write-port controller.
// Holds the port word used by the grant mux and the controller state enum.
package regfile_pkg;

   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int NREGS = 32;
   localparam int WCW   = 4;

   typedef enum logic {INIT, RUN} wb_state_t;

   typedef struct packed {
      logic            we;
      logic [AW-1:0]   wa;
      logic [XLEN-1:0] wd;
   } rf_wr_t;

   // An idle port carries all zeros so the register file never sees X.
   function automatic rf_wr_t cleanPort(input rf_wr_t w);
      return w.we ? w : '0;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the core writeback, aux handshake and register-file write port.
// The master side is the requesters plus regFile; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
   parameter int XLEN = regfile_pkg::XLEN,
   parameter int AW   = regfile_pkg::AW
);
   logic            core_we;
   logic [AW-1:0]   core_wa;
   logic [XLEN-1:0] core_wd;
   logic            core_stall;
   logic            aux_valid;
   logic [AW-1:0]   aux_wa;
   logic [XLEN-1:0] aux_wd;
   logic            aux_ready;
   logic            init_busy;
   logic            WE3;
   logic [AW-1:0]   WA3;
   logic [XLEN-1:0] WD3;

   modport master (
      output core_we, core_wa, core_wd, aux_valid, aux_wa, aux_wd,
      input  core_stall, aux_ready, init_busy, WE3, WA3, WD3
   );

   modport slave (
      input  core_we, core_wa, core_wd, aux_valid, aux_wa, aux_wd,
      output core_stall, aux_ready, init_busy, WE3, WA3, WD3
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller: zeroes x1..x31 after reset, then shares WE3/WA3/WD3
// between the core writeback (priority) and an aux requester with anti-starvation.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input logic clk,
   input logic reset,
   regfile_wb_arbiter_if.slave bus
);

   wb_state_t      state_q, state_d;
   logic [AW-1:0]  init_cnt_q, init_cnt_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

   rf_wr_t coreWr, auxWr, sel, portWr;
   logic   coreEff, starve, stall, ready, busy;

   assign coreEff = bus.core_we && (bus.core_wa != '0);
   assign starve  = bus.aux_valid && (wait_cnt_q == WCW'(MAX_WAIT));
   assign coreWr  = '{we: coreEff, wa: bus.core_wa, wd: bus.core_wd};
   assign auxWr   = '{we: (bus.aux_wa != '0), wa: bus.aux_wa, wd: bus.aux_wd};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         init_cnt_q <= AW'(1);
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // While reset is high the defaults below are the forced reset outputs.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      wait_cnt_d = wait_cnt_q;
      sel        = '0;
      stall      = 1'b1;
      ready      = 1'b0;
      busy       = 1'b1;
      if (!reset) begin
         case (state_q)
            INIT: begin
               sel.we     = 1'b1;
               sel.wa     = init_cnt_q;
               init_cnt_d = init_cnt_q + AW'(1);
               if (init_cnt_q == AW'(NREGS - 1)) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               busy  = 1'b0;
               stall = 1'b0;
               if (starve) begin
                  // The core holds its inputs, so its dropped write returns next cycle.
                  stall = 1'b1;
                  ready = 1'b1;
                  sel   = auxWr;
               end else if (coreEff) begin
                  sel = coreWr;
               end else begin
                  ready = bus.aux_valid;
                  if (bus.aux_valid) begin
                     sel = auxWr;
                  end
               end
               if (bus.aux_valid && !ready) begin
                  wait_cnt_d = (wait_cnt_q == WCW'(MAX_WAIT)) ? wait_cnt_q
                                                              : wait_cnt_q + WCW'(1);
               end else begin
                  wait_cnt_d = '0;
               end
            end
         endcase
      end
   end

   assign portWr         = cleanPort(sel);
   assign bus.WE3        = portWr.we;
   assign bus.WA3        = portWr.wa;
   assign bus.WD3        = portWr.wd;
   assign bus.core_stall = stall;
   assign bus.aux_ready  = ready;
   assign bus.init_busy  = busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: each stimulus cycle queues its expected port/handshake word,
// and a negedge monitor pops and compares; a small regFile model checks contents.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   typedef struct packed {
      logic            we;
      logic [AW-1:0]   wa;
      logic [XLEN-1:0] wd;
      logic            stall;
      logic            ready;
      logic            busy;
   } obs_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   obs_t  expQ[$];
   string tagQ[$];
   obs_t  monExp, monAct;
   string monTag;

   logic [XLEN-1:0] rf [NREGS];
   logic            seeded = 1'b0;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter #(.MAX_WAIT(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // regFile model: seeded with junk so the init sweep has something to clear.
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= (i == 0) ? '0 : (32'hBAD0_0000 + XLEN'(i));
         seeded <= 1'b1;
      end else if (bus.WE3 === 1'b1) begin
         rf[bus.WA3] <= bus.WD3;
      end
   end

   function automatic obs_t mk(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                               input logic st, input logic rd, input logic bz);
      obs_t o;
      o = '{we: we, wa: wa, wd: wd, stall: st, ready: rd, busy: bz};
      return o;
   endfunction

   task automatic checkOutput(input string tag, input obs_t e, input obs_t a);
      checks++;
      if (a !== e) begin
         errors++;
         $display("[TB] FAIL %s: got we=%b wa=%0d wd=%h stall=%b ready=%b busy=%b, expected we=%b wa=%0d wd=%h stall=%b ready=%b busy=%b",
                  tag, a.we, a.wa, a.wd, a.stall, a.ready, a.busy,
                  e.we, e.wa, e.wd, e.stall, e.ready, e.busy);
      end
   endtask

   task automatic checkReg(input string tag, input int idx, input logic [XLEN-1:0] e);
      checks++;
      if (rf[idx] !== e) begin
         errors++;
         $display("[TB] FAIL %s: x%0d got %h, expected %h", tag, idx, rf[idx], e);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         monTag = tagQ.pop_front();
         monAct = '{we: bus.WE3, wa: bus.WA3, wd: bus.WD3,
                    stall: bus.core_stall, ready: bus.aux_ready, busy: bus.init_busy};
         checkOutput(monTag, monExp, monAct);
      end
   end

   task automatic applyStimulus(input string tag, input logic rst,
                                input logic cwe, input logic [AW-1:0] cwa, input logic [XLEN-1:0] cwd,
                                input logic av, input logic [AW-1:0] awa, input logic [XLEN-1:0] awd,
                                input obs_t e);
      @(posedge clk);
      #1;
      reset         = rst;
      bus.core_we   = cwe;
      bus.core_wa   = cwa;
      bus.core_wd   = cwd;
      bus.aux_valid = av;
      bus.aux_wa    = awa;
      bus.aux_wd    = awd;
      expQ.push_back(e);
      tagQ.push_back(tag);
   endtask

   task automatic sweep(input string tag, input logic cwe, input logic [AW-1:0] cwa,
                        input logic [XLEN-1:0] cwd, input logic av, input logic [AW-1:0] awa,
                        input logic [XLEN-1:0] awd);
      for (int i = 1; i <= 31; i++) begin
         applyStimulus($sformatf("%s x%0d", tag, i), 1'b0, cwe, cwa, cwd, av, awa, awd,
                       mk(1'b1, AW'(i), '0, 1'b1, 1'b0, 1'b1));
      end
   endtask

   // Four core writes win, the fifth cycle is a forced aux grant, then the core retries.
   task automatic starveSeq(input string tag, input logic [AW-1:0] awa, input logic [XLEN-1:0] awd,
                            input int waBase, input int wdBase);
      for (int k = 0; k < 4; k++) begin
         applyStimulus($sformatf("%s core%0d", tag, k), 1'b0, 1'b1, AW'(waBase + k), XLEN'(wdBase + k),
                       1'b1, awa, awd, mk(1'b1, AW'(waBase + k), XLEN'(wdBase + k), 1'b0, 1'b0, 1'b0));
      end
      applyStimulus({tag, " grant"}, 1'b0, 1'b1, AW'(waBase + 4), XLEN'(wdBase + 4),
                    1'b1, awa, awd, mk(1'b1, awa, awd, 1'b1, 1'b1, 1'b0));
      applyStimulus({tag, " retry"}, 1'b0, 1'b1, AW'(waBase + 4), XLEN'(wdBase + 4),
                    1'b0, '0, '0, mk(1'b1, AW'(waBase + 4), XLEN'(wdBase + 4), 1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      obs_t rstObs, idleObs;
      rstObs  = mk(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      idleObs = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      bus.core_we = 1'b0; bus.core_wa = '0; bus.core_wd = '0;
      bus.aux_valid = 1'b0; bus.aux_wa = '0; bus.aux_wd = '0;

      applyStimulus("reset0", 1'b1, 0, 0, 0, 0, 0, 0, rstObs);
      applyStimulus("reset1", 1'b1, 0, 0, 0, 0, 0, 0, rstObs);
      for (int i = 1; i <= 9; i++) begin
         applyStimulus($sformatf("sweepA x%0d", i), 1'b0, 0, 0, 0, 0, 0, 0,
                       mk(1'b1, AW'(i), '0, 1'b1, 1'b0, 1'b1));
      end
      applyStimulus("resetMidSweep", 1'b1, 0, 0, 0, 0, 0, 0, rstObs);
      sweep("sweepB", 0, 0, 0, 0, 0, 0);

      applyStimulus("coreWr", 1'b0, 1, 1, 32'd12345678, 0, 0, 0,
                    mk(1'b1, 5'd1, 32'd12345678, 1'b0, 1'b0, 1'b0));
      for (int i = 1; i <= 31; i++) checkReg($sformatf("zeroed x%0d", i), i, '0);
      applyStimulus("coreX0", 1'b0, 1, 0, 32'd555, 0, 0, 0, idleObs);
      checkReg("coreWr data", 1, 32'd12345678);

      applyStimulus("auxIdleCore", 1'b0, 0, 0, 0, 1, 2, 32'hDEADBEEF,
                    mk(1'b1, 5'd2, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0));
      applyStimulus("idle", 1'b0, 0, 0, 0, 0, 0, 0, idleObs);
      checkReg("aux data", 2, 32'hDEADBEEF);

      starveSeq("starve1", 5'd3, 32'hA5A5A5A5, 10, 100);
      starveSeq("starve2", 5'd7, 32'd77, 20, 200);

      applyStimulus("auxX0", 1'b0, 0, 0, 0, 1, 0, 32'hFFFF,
                    mk(1'b0, '0, '0, 1'b0, 1'b1, 1'b0));
      applyStimulus("idle2", 1'b0, 0, 0, 0, 0, 0, 0, idleObs);
      checkReg("x0 stays zero", 0, '0);
      checkReg("starve1 aux", 3, 32'hA5A5A5A5);
      checkReg("starve1 retry", 14, 32'd104);
      checkReg("starve2 aux", 7, 32'd77);

      applyStimulus("pend0", 1'b0, 1, 6, 1, 1, 5, 32'hCAFE, mk(1'b1, 5'd6, 32'd1, 1'b0, 1'b0, 1'b0));
      applyStimulus("pend1", 1'b0, 1, 6, 1, 1, 5, 32'hCAFE, mk(1'b1, 5'd6, 32'd1, 1'b0, 1'b0, 1'b0));
      applyStimulus("resetPending", 1'b1, 1, 6, 1, 1, 5, 32'hCAFE, rstObs);
      sweep("sweepC", 1, 6, 1, 1, 5, 32'hCAFE);
      starveSeq("starve3", 5'd5, 32'hCAFE, 16, 300);
      applyStimulus("idle3", 1'b0, 0, 0, 0, 0, 0, 0, idleObs);
      checkReg("pending aux", 5, 32'hCAFE);
      checkReg("sweep cleared x6", 6, '0);
      checkReg("starve3 retry", 20, 32'd304);

      for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
      #1;
      if (expQ.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d expected words left, expected 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
